// File: rtl/sd_photo_pkg.sv
// Shared types and helpers for the SD card BMP photo writer.
package sd_photo_pkg;

    localparam int SEC_WORDS      = 256;
    localparam int BMP_HEAD_WORDS = 27;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEC_START,
        ST_SEC_WAIT,
        ST_DONE
    } state_e;

    // Returns {R8, G8, B8}; the low bits replicate the top bits so full scale maps to 8'hFF.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] n);
        return v[{n, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bmp_word_gen.sv
// Produces the BMP file as a stream of 16-bit words: header ROM, packed pixels, zero pad.
// The register wr_data_o always holds the word the SD controller will consume next.
module bmp_word_gen
    import sd_photo_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart_i,
    input  logic        active_i,
    input  logic        wr_req_i,
    input  logic [15:0] rd_data_i,
    output logic        rd_en_o,
    output logic [15:0] wr_data_o
);

    localparam logic [31:0] PIX_BYTES  = 32'(3 * IMG_W * IMG_H);
    localparam logic [31:0] PIX_WORDS  = PIX_BYTES / 32'd2;
    localparam logic [31:0] FILE_BYTES = 32'd54 + PIX_BYTES;
    localparam logic [31:0] PIX_END    = 32'(BMP_HEAD_WORDS) + PIX_WORDS;

    // All multi-byte header fields start at byte offset 2 mod 4, so one 4-byte slot index covers them.
    function automatic logic [7:0] hdr_byte(input logic [5:0] i);
        logic [5:0]  off;
        logic [31:0] field;
        off = i - 6'd2;
        case (off[5:2])
            4'd0:    field = FILE_BYTES;
            4'd2:    field = 32'd54;
            4'd3:    field = 32'd40;
            4'd4:    field = 32'(IMG_W);
            4'd5:    field = 32'(IMG_H);
            4'd6:    field = 32'h0018_0001;
            4'd8:    field = PIX_BYTES;
            default: field = 32'd0;
        endcase
        if (i == 6'd0) return 8'h42;
        if (i == 6'd1) return 8'h4D;
        return le_byte(field, off[1:0]);
    endfunction

    function automatic logic [15:0] hdr_word(input logic [4:0] k);
        return {hdr_byte({k, 1'b0}), hdr_byte({k, 1'b1})};
    endfunction

    logic [31:0] w_q;
    logic [1:0]  ph_q;
    logic        rd_en_q;
    logic        cap_q;
    logic [7:0]  r0_q;
    logic [15:0] p1_q;
    logic [15:0] data_q;
    logic [31:0] nxt_w;
    logic [23:0] pix;

    assign nxt_w = w_q + 32'd1;
    assign pix   = rgb565_to_888(rd_data_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q     <= 32'd0;
            ph_q    <= 2'd0;
            rd_en_q <= 1'b0;
            cap_q   <= 1'b0;
            r0_q    <= 8'd0;
            p1_q    <= 16'd0;
            data_q  <= 16'd0;
        end else begin
            rd_en_q <= 1'b0;
            cap_q   <= rd_en_q;
            if (restart_i) begin
                w_q    <= 32'd0;
                ph_q   <= 2'd0;
                cap_q  <= 1'b0;
                data_q <= hdr_word(5'd0);
            end else if (!active_i) begin
                data_q <= 16'd0;
            end else if (cap_q) begin
                // Pixel arrives two cycles after the request that needed it.
                if (ph_q == 2'd0) begin
                    r0_q   <= pix[23:16];
                    data_q <= {pix[7:0], pix[15:8]};
                    ph_q   <= 2'd1;
                end else begin
                    p1_q   <= pix[23:8];
                    data_q <= {r0_q, pix[7:0]};
                    ph_q   <= 2'd2;
                end
            end else if (wr_req_i) begin
                w_q <= nxt_w;
                if (nxt_w < 32'(BMP_HEAD_WORDS)) begin
                    data_q <= hdr_word(nxt_w[4:0]);
                end else if (nxt_w < PIX_END) begin
                    if (ph_q == 2'd2) begin
                        data_q <= {p1_q[7:0], p1_q[15:8]};
                        ph_q   <= 2'd0;
                    end else begin
                        rd_en_q <= 1'b1;
                    end
                end else begin
                    data_q <= 16'd0;
                end
            end
        end
    end

    assign rd_en_o   = rd_en_q;
    assign wr_data_o = data_q;

endmodule

// File: rtl/sd_write_photo.sv
// Writes one SDRAM frame to the SD card as a bottom-up 24-bit BMP, one 512-byte sector at a time.
// Sector sequencing lives here; word content comes from bmp_word_gen.
module sd_write_photo
    import sd_photo_pkg::*;
#(
    parameter int          IMG_W          = 640,
    parameter int          IMG_H          = 480,
    parameter logic [31:0] PHOTO_SEC_ADDR = 32'd16448
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        sdram_rd_rst,
    output logic        sdram_rd_en,
    input  logic [15:0] sdram_rd_data,
    output logic        sd_wr_start_en,
    output logic [31:0] sd_wr_sec_addr,
    input  logic        sd_wr_busy,
    input  logic        sd_wr_req,
    output logic [15:0] sd_wr_data
);

    localparam logic [31:0] FILE_BYTES = 32'(54 + 3 * IMG_W * IMG_H);
    localparam logic [31:0] SEC_BYTES  = 32'(2 * SEC_WORDS);
    localparam logic [31:0] SEC_NUM    = (FILE_BYTES + SEC_BYTES - 32'd1) / SEC_BYTES;

    state_e      state_q;
    logic [31:0] sec_cnt_q;
    logic [31:0] addr_q;
    logic        busy_q;
    logic        done_q;
    logic        rd_rst_q;
    logic        start_en_q;
    logic        busy_s0_q;
    logic        busy_s1_q;
    logic        busy_fall;
    logic        gen_active;
    logic        gen_restart;

    assign busy_fall   = busy_s1_q & ~busy_s0_q;
    assign gen_restart = (state_q == ST_LOAD);
    assign gen_active  = (state_q == ST_LOAD) || (state_q == ST_SEC_START) || (state_q == ST_SEC_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_s0_q <= 1'b0;
            busy_s1_q <= 1'b0;
        end else begin
            busy_s0_q <= sd_wr_busy;
            busy_s1_q <= busy_s0_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sec_cnt_q  <= 32'd0;
            addr_q     <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_rst_q   <= 1'b0;
            start_en_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_rst_q   <= 1'b0;
            start_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_LOAD;
                        busy_q    <= 1'b1;
                        rd_rst_q  <= 1'b1;
                        sec_cnt_q <= 32'd0;
                    end
                end
                ST_LOAD: begin
                    state_q    <= ST_SEC_START;
                    start_en_q <= 1'b1;
                    addr_q     <= PHOTO_SEC_ADDR + sec_cnt_q;
                end
                ST_SEC_START: state_q <= ST_SEC_WAIT;
                ST_SEC_WAIT: begin
                    if (busy_fall) begin
                        if (sec_cnt_q == SEC_NUM - 32'd1) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_SEC_START;
                            sec_cnt_q  <= sec_cnt_q + 32'd1;
                            addr_q     <= PHOTO_SEC_ADDR + sec_cnt_q + 32'd1;
                            start_en_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    bmp_word_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_word_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (gen_restart),
        .active_i  (gen_active),
        .wr_req_i  (sd_wr_req),
        .rd_data_i (sdram_rd_data),
        .rd_en_o   (sdram_rd_en),
        .wr_data_o (sd_wr_data)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign sdram_rd_rst   = rd_rst_q;
    assign sd_wr_start_en = start_en_q;
    assign sd_wr_sec_addr = addr_q;

endmodule

// File: tb/tb_sd_write_photo.sv
// Bench for sd_write_photo at 16x16: SDRAM and SD controller models, word scoreboard, summary.
module tb_sd_write_photo;

    localparam int W      = 16;
    localparam int H      = 16;
    localparam int NPIX   = W * H;
    localparam int NWORDS = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        sdram_rd_rst;
    logic        sdram_rd_en;
    logic [15:0] sdram_rd_data = 16'h0;
    logic        sd_wr_start_en;
    logic [31:0] sd_wr_sec_addr;
    logic        sd_wr_busy = 1'b0;
    logic        sd_wr_req = 1'b0;
    logic [15:0] sd_wr_data;

    int n_pass = 0;
    int n_total = 0;

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    sd_write_photo #(
        .IMG_W          (W),
        .IMG_H          (H),
        .PHOTO_SEC_ADDR (32'd16448)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .sdram_rd_rst   (sdram_rd_rst),
        .sdram_rd_en    (sdram_rd_en),
        .sdram_rd_data  (sdram_rd_data),
        .sd_wr_start_en (sd_wr_start_en),
        .sd_wr_sec_addr (sd_wr_sec_addr),
        .sd_wr_busy     (sd_wr_busy),
        .sd_wr_req      (sd_wr_req),
        .sd_wr_data     (sd_wr_data)
    );

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endfunction

    // ---------------- SDRAM read port model ----------------
    logic [15:0] img [NPIX];
    int rd_ptr = 0;

    always @(posedge clk) begin
        if (sdram_rd_rst) begin
            rd_ptr <= 0;
        end else if (sdram_rd_en) begin
            sdram_rd_data <= (rd_ptr < NPIX) ? img[rd_ptr] : 16'hDEAD;
            rd_ptr <= rd_ptr + 1;
        end
    end

    // ---------------- event counters ----------------
    int          rd_en_cnt = 0;
    int          rd_rst_cnt = 0;
    int          done_cnt = 0;
    bit          start_seen = 1'b0;
    logic [31:0] start_addr = 32'd0;

    always @(negedge clk) begin
        if (sdram_rd_en) rd_en_cnt++;
        if (sdram_rd_rst) rd_rst_cnt++;
        if (done) done_cnt++;
        if (sd_wr_start_en) begin
            start_seen = 1'b1;
            start_addr = sd_wr_sec_addr;
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    int          mon_idx = 0;

    always @(negedge clk) begin
        if (sd_wr_req) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_word got=%h exp=none", sd_wr_data);
            end else begin
                exp_w = exp_q.pop_front();
                chk($sformatf("word%0d", mon_idx), 32'(sd_wr_data), 32'(exp_w));
                mon_idx++;
            end
        end
    end

    // Hand-computed: 27 header words for a 16x16 file of 822 bytes, then the words of pixels F800,07E0,FFFF,0000.
    logic [15:0] hand_w [33];

    task automatic push_frame();
        logic [7:0] fb [0:1023];
        logic [7:0] r, g, b;
        logic [15:0] p;
        for (int i = 0; i < 1024; i++) fb[i] = 8'h00;
        for (int k = 0; k < 27; k++) begin
            fb[2*k]   = hand_w[k][15:8];
            fb[2*k+1] = hand_w[k][7:0];
        end
        for (int i = 0; i < NPIX; i++) begin
            p = img[i];
            r = {3'b000, p[15:11]};
            g = {2'b00, p[10:5]};
            b = {3'b000, p[4:0]};
            fb[54 + 3*i] = (b << 3) | (b >> 2);
            fb[55 + 3*i] = (g << 2) | (g >> 4);
            fb[56 + 3*i] = (r << 3) | (r >> 2);
        end
        mon_idx = 0;
        for (int k = 0; k < NWORDS; k++) begin
            if (k < 33) exp_q.push_back(hand_w[k]);
            else exp_q.push_back({fb[2*k], fb[2*k+1]});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic serve_sector(input logic [31:0] exp_addr, input int n_req, input int gap, input bit drop_busy);
        int t;
        t = 0;
        while (!start_seen && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!start_seen) begin
            n_total++;
            $display("FAIL start_en_timeout got=none exp=pulse within %0d cycles", t);
        end else begin
            chk("sec_addr", start_addr, exp_addr);
        end
        start_seen = 1'b0;
        @(posedge clk); #1 sd_wr_busy = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < n_req; i++) begin
            @(posedge clk); #1 sd_wr_req = 1'b1;
            @(posedge clk); #1 sd_wr_req = 1'b0;
            repeat (gap - 2) @(posedge clk);
        end
        if (drop_busy) begin
            repeat (2) @(posedge clk);
            #1 sd_wr_busy = 1'b0;
        end
    endtask

    task automatic run_frame(input int gap, input bit extra_start);
        int d0, e0, r0, t;
        d0 = done_cnt;
        e0 = rd_en_cnt;
        r0 = rd_rst_cnt;
        push_frame();
        pulse_start();
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("rd_rst_pulse", 32'(sdram_rd_rst), 32'd1);
        if (extra_start) pulse_start();
        serve_sector(32'd16448, 256, gap, 1'b1);
        serve_sector(32'd16449, 256, gap, 1'b1);
        chk("no_early_done", 32'(done_cnt), 32'(d0));
        t = 0;
        while (done_cnt == d0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done_count", 32'(done_cnt), 32'(d0 + 1));
        @(negedge clk);
        @(negedge clk);
        chk("busy_cleared", 32'(busy), 32'd0);
        chk("done_single", 32'(done_cnt), 32'(d0 + 1));
        chk("rd_en_count", 32'(rd_en_cnt - e0), 32'd256);
        chk("rd_rst_count", 32'(rd_rst_cnt - r0), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rd_rst"}, 32'(sdram_rd_rst), 32'd0);
        chk({tag, "_rd_en"}, 32'(sdram_rd_en), 32'd0);
        chk({tag, "_start_en"}, 32'(sd_wr_start_en), 32'd0);
        chk({tag, "_addr"}, sd_wr_sec_addr, 32'd0);
        chk({tag, "_data"}, 32'(sd_wr_data), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int d_before;
        hand_w = '{16'h424D, 16'h3603, 16'h0000, 16'h0000, 16'h0000, 16'h3600, 16'h0000,
                   16'h2800, 16'h0000, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 16'h0100,
                   16'h1800, 16'h0000, 16'h0000, 16'h0003, 16'h0000,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                   16'h0000, 16'hFF00, 16'hFF00, 16'hFFFF, 16'hFF00, 16'h0000};
        img[0] = 16'hF800;
        img[1] = 16'h07E0;
        img[2] = 16'hFFFF;
        img[3] = 16'h0000;
        for (int i = 4; i < NPIX; i++) img[i] = 16'((i * 40503) ^ (i << 7));

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // A request while idle must not disturb the zero output word.
        mon_idx = 0;
        exp_q.push_back(16'h0000);
        @(posedge clk); #1 sd_wr_req = 1'b1;
        @(posedge clk); #1 sd_wr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_req_busy", 32'(busy), 32'd0);
        chk("idle_req_data", 32'(sd_wr_data), 32'd0);

        // Back-to-back requests at minimum spacing, plus a start pulse while busy.
        run_frame(4, 1'b1);
        repeat (5) @(posedge clk);
        run_frame($urandom_range(4, 6), 1'b0);
        repeat (5) @(posedge clk);

        // Abort mid-sector, then restart from scratch.
        d_before = done_cnt;
        push_frame();
        pulse_start();
        serve_sector(32'd16448, 17, 5, 1'b0);
        @(negedge clk);
        chk("abort_data_before", 32'(sd_wr_data), 32'h0003);
        @(posedge clk); #1 rst_n = 1'b0;
        #2;
        check_outputs_zero("abort");
        sd_wr_busy = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_on_abort", 32'(done_cnt), 32'(d_before));
        run_frame(5, 1'b0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
